// File: rtl/and_seq_pkg.sv
// Shared types and default sizes for the AND gate stimulus sequencer and settle monitor.
// Optional input synchronizer is enabled by defining AND_SEQ_SYNC_EN (see and_delay_sequencer).
package and_seq_pkg;

  localparam int NUM_OUT_DEF   = 5;
  localparam int NUM_STEPS_DEF = 8;
  localparam int HOLD_W_DEF    = 4;
  localparam int CNT_W_DEF     = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    CHECK,
    DONE
  } state_e;

  typedef struct packed {
    logic                  a;
    logic                  b;
    logic [HOLD_W_DEF-1:0] hold;
  } step_t;

  // A zero hold still occupies one HOLD cycle.
  function automatic logic [HOLD_W_DEF-1:0] eff_hold(input logic [HOLD_W_DEF-1:0] h);
    return (h == '0) ? HOLD_W_DEF'(1) : h;
  endfunction

endpackage

// File: rtl/and_settle_counter.sv
// Per-output settle counter: counts mismatching cycles until the first match of a step,
// then keeps the largest per-step count seen over the run.
module and_settle_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             match_i,
  input  logic             max_clr_i,
  input  logic             max_upd_i,
  output logic [CNT_W-1:0] max_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frozen_q, frozen_d;
  logic [CNT_W-1:0] max_q, max_d;

  always_comb begin
    cnt_d    = cnt_q;
    frozen_d = frozen_q;
    max_d    = max_q;
    if (clr_i) begin
      cnt_d    = '0;
      frozen_d = 1'b0;
    end else if (en_i && !frozen_q) begin
      // First match freezes the count so later glitches are not recounted.
      if (match_i) begin
        frozen_d = 1'b1;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (max_clr_i) begin
      max_d = '0;
    end else if (max_upd_i && (cnt_q > max_q)) begin
      max_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      frozen_q <= 1'b0;
      max_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      frozen_q <= frozen_d;
      max_q    <= max_d;
    end
  end

  assign max_o = max_q;

endmodule

// File: rtl/and_delay_sequencer.sv
// Replays a {a, b, hold} table onto AND gate inputs and measures per-output settle time.
// Define AND_SEQ_SYNC_EN to pass and_in through a 2-flop synchronizer (counts then include +2).
module and_delay_sequencer
  import and_seq_pkg::*;
#(
  parameter int NUM_OUT   = NUM_OUT_DEF,
  parameter int NUM_STEPS = NUM_STEPS_DEF,
  parameter int HOLD_W    = HOLD_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(NUM_STEPS):0]   num_steps_i,
  input  logic                         step_wr_en,
  input  logic [$clog2(NUM_STEPS)-1:0] step_wr_addr,
  input  logic [HOLD_W+1:0]            step_wr_data,
  output logic                         a_out,
  output logic                         b_out,
  input  logic [NUM_OUT-1:0]           and_in,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_OUT*CNT_W-1:0]     settle_cnt_o,
  output logic [NUM_OUT-1:0]           mismatch_o,
  output state_e                       state_o
);

  localparam int IDX_W = $clog2(NUM_STEPS);
  localparam int NS_W  = IDX_W + 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NS_W-1:0]   nsteps_q, nsteps_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              a_q, a_d, b_q, b_d;
  logic [NUM_OUT-1:0] mm_q, mm_d;
  step_t             tbl_q [NUM_STEPS];
  logic              load_step, run_clr, cnt_en, chk;
  logic              exp_bit;
  logic [NUM_OUT-1:0] and_cmp;

  // Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse, busy spans LOAD..CHECK.
  assign busy    = (state_q == LOAD) || (state_q == HOLD) || (state_q == CHECK);
  assign done    = (state_q == DONE);
  assign cnt_en  = (state_q == LOAD) || (state_q == HOLD);
  assign chk     = (state_q == CHECK);
  assign exp_bit = a_q & b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) tbl_q[i] <= '0;
    end else if (step_wr_en && !busy) begin
      tbl_q[step_wr_addr] <= step_t'(step_wr_data);
    end
  end

`ifdef AND_SEQ_SYNC_EN
  logic [NUM_OUT-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= and_in;
      sync2_q <= sync1_q;
    end
  end

  assign and_cmp = sync2_q;
`else
  assign and_cmp = and_in;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nsteps_d  = nsteps_q;
    hold_d    = hold_q;
    a_d       = a_q;
    b_d       = b_q;
    mm_d      = mm_q;
    load_step = 1'b0;
    run_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          nsteps_d = (num_steps_i > NS_W'(NUM_STEPS)) ? NS_W'(NUM_STEPS) : num_steps_i;
          if (num_steps_i == '0) begin
            state_d = DONE;
          end else begin
            run_clr   = 1'b1;
            idx_d     = '0;
            load_step = 1'b1;
            state_d   = LOAD;
          end
        end
      end
      LOAD: state_d = HOLD;
      HOLD: begin
        if (hold_q <= HOLD_W'(1)) state_d = CHECK;
        else                      hold_d  = hold_q - HOLD_W'(1);
      end
      CHECK: begin
        mm_d = mm_q | (and_cmp ^ {NUM_OUT{exp_bit}});
        if (NS_W'(idx_q) + NS_W'(1) == nsteps_q) begin
          state_d = DONE;
        end else begin
          idx_d     = idx_q + IDX_W'(1);
          load_step = 1'b1;
          state_d   = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (run_clr) mm_d = '0;
    // Gate drive and hold length change on the same edge that enters LOAD.
    if (load_step) begin
      a_d    = tbl_q[idx_d].a;
      b_d    = tbl_q[idx_d].b;
      hold_d = eff_hold(tbl_q[idx_d].hold);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      nsteps_q <= '0;
      hold_q   <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      mm_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nsteps_q <= nsteps_d;
      hold_q   <= hold_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mm_q     <= mm_d;
    end
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_settle
    and_settle_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (load_step),
      .en_i      (cnt_en),
      .match_i   (and_cmp[i] == exp_bit),
      .max_clr_i (run_clr),
      .max_upd_i (chk),
      .max_o     (settle_cnt_o[i*CNT_W +: CNT_W])
    );
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign mismatch_o = mm_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_and_delay_sequencer.sv
// Bench for and_delay_sequencer: table replay, delayed/stuck gate outputs, busy guards,
// zero-hold and zero-step runs, and reset in the middle of a hold.
module tb_and_delay_sequencer;
  import and_seq_pkg::*;

  localparam int NUM_OUT   = 5;
  localparam int NUM_STEPS = 8;
  localparam int HOLD_W    = 4;
  localparam int CNT_W     = 8;
  localparam int CW        = NUM_OUT * CNT_W;
  localparam int RW        = 16 + NUM_OUT + CW;

`ifdef AND_SEQ_SYNC_EN
  localparam int             BASE = 2;
  localparam int             DLY2 = 4;
  localparam logic [NUM_OUT-1:0] MM2 = 5'b00100;
`else
  localparam int             BASE = 0;
  localparam int             DLY2 = 2;
  localparam logic [NUM_OUT-1:0] MM2 = 5'b00000;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  start = 1'b0;
  logic [3:0]            num_steps_i = '0;
  logic                  step_wr_en = 1'b0;
  logic [2:0]            step_wr_addr = '0;
  logic [HOLD_W+1:0]     step_wr_data = '0;
  logic                  a_out, b_out, busy, done;
  logic [NUM_OUT-1:0]    and_in;
  logic [CW-1:0]         settle_cnt_o;
  logic [NUM_OUT-1:0]    mismatch_o;
  state_e                state_o;

  and_delay_sequencer #(
    .NUM_OUT(NUM_OUT), .NUM_STEPS(NUM_STEPS), .HOLD_W(HOLD_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_steps_i(num_steps_i),
    .step_wr_en(step_wr_en), .step_wr_addr(step_wr_addr), .step_wr_data(step_wr_data),
    .a_out(a_out), .b_out(b_out), .and_in(and_in), .busy(busy), .done(done),
    .settle_cnt_o(settle_cnt_o), .mismatch_o(mismatch_o), .state_o(state_o)
  );

  // ---------------- gate model: 0 ideal, 1 output 2 delayed 2 cycles, 2 output 4 stuck 0 ----------------
  int   mode = 0;
  logic d1 = 1'b0;
  logic d2 = 1'b0;
  always @(posedge clk) begin
    d1 <= a_out & b_out;
    d2 <= d1;
  end
  always_comb begin
    and_in = {NUM_OUT{a_out & b_out}};
    if (mode == 1) and_in[2] = d2;
    if (mode == 2) and_in[4] = 1'b0;
  end

  // ---------------- monitors ----------------
  int busy_cyc = 0;
  int hold_cyc = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (state_o == HOLD) hold_cyc++;
    if (done) done_cnt++;
  end

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt_vec(input int base, input int idx, input int val);
    logic [CW-1:0] v;
    for (int i = 0; i < NUM_OUT; i++) v[i*CNT_W +: CNT_W] = CNT_W'(base);
    if (idx >= 0) v[idx*CNT_W +: CNT_W] = CNT_W'(val);
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic write_step(input int addr, input bit a, input bit b, input int hold);
    @(negedge clk);
    step_wr_en   = 1'b1;
    step_wr_addr = 3'(addr);
    step_wr_data = {a, b, 4'(hold)};
    @(negedge clk);
    step_wr_en   = 1'b0;
  endtask

  task automatic run_seq(input int n, input int exp_busy, input int exp_hold,
                         input logic [NUM_OUT-1:0] exp_mm, input logic [CW-1:0] exp_cnt,
                         input bit disturb);
    logic [RW-1:0] rec;
    int c;
    int d0;
    exp_q.push_back({8'(exp_busy), 8'(exp_hold), exp_mm, exp_cnt});
    @(negedge clk);
    busy_cyc    = 0;
    hold_cyc    = 0;
    d0          = done_cnt;
    num_steps_i = 4'(n);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (disturb) begin
      repeat (4) @(negedge clk);
      start        = 1'b1;
      num_steps_i  = 4'd1;
      step_wr_en   = 1'b1;
      step_wr_addr = '0;
      step_wr_data = {1'b1, 1'b1, 4'hf};
      @(negedge clk);
      start      = 1'b0;
      step_wr_en = 1'b0;
    end
    c = 0;
    while (!done && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", done, 1);
    rec = exp_q.pop_front();
    check("busy_cycles", busy_cyc, rec[RW-1 -: 8]);
    check("hold_cycles", hold_cyc, rec[RW-9 -: 8]);
    check("mismatch", mismatch_o, rec[CW +: NUM_OUT]);
    for (int i = 0; i < NUM_OUT; i++)
      check($sformatf("settle%0d", i), settle_cnt_o[i*CNT_W +: CNT_W], rec[i*CNT_W +: CNT_W]);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("no_requeue", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    int d0;
    repeat (3) @(negedge clk);
    check("rst_a", a_out, 0);
    check("rst_b", b_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_settle", settle_cnt_o, 0);
    check("rst_mismatch", mismatch_o, 0);
    rst_n = 1'b1;

    write_step(0, 0, 0, 4);
    write_step(1, 1, 1, 3);
    write_step(2, 1, 0, 3);
    write_step(3, 1, 1, 1);
    write_step(4, 0, 1, 6);

    mode = 0;
    run_seq(5, 27, 17, '0, cnt_vec(BASE, -1, 0), 1'b0);
    mode = 1;
    run_seq(5, 27, 17, MM2, cnt_vec(BASE, 2, DLY2), 1'b0);
    mode = 2;
    run_seq(5, 27, 17, 5'b10000, cnt_vec(BASE, 4, 4), 1'b0);
    mode = 0;
    run_seq(5, 27, 17, '0, cnt_vec(BASE, -1, 0), 1'b1);
    run_seq(5, 27, 17, '0, cnt_vec(BASE, -1, 0), 1'b0);
    // Zero-step run: straight to DONE, previous results retained.
    run_seq(0, 0, 0, '0, cnt_vec(BASE, -1, 0), 1'b0);

    write_step(0, 1, 1, 0);
    run_seq(1, 3, 1, '0, cnt_vec(BASE, -1, 0), 1'b0);

    // Reset in the middle of a hold.
    write_step(0, 1, 1, 5);
    @(negedge clk);
    num_steps_i = 4'd1;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (state_o != HOLD && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("reached_hold", state_o == HOLD, 1);
    @(negedge clk);
    check("pre_rst_a", a_out, 1);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_a", a_out, 0);
    check("midrst_b", b_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", state_o == IDLE, 1);
    check("midrst_settle", settle_cnt_o, 0);
    check("midrst_mismatch", mismatch_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    // Table was cleared by reset: two zero entries, one HOLD cycle each.
    run_seq(2, 6, 2, '0, cnt_vec(0, -1, 0), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
